serial_mag_compare_ctrl: RTL and testbench

//   Multi-cycle controller that compares two WIDTH-bit unsigned operands using one
//   2-bit slice comparator, one slice per cycle, most significant slice first.

---
 rtl/serial_mag_compare_ctrl_pkg.sv | 19 +
 rtl/serial_mag_compare_ctrl_greater.sv | 11 +
 rtl/serial_mag_compare_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_mag_compare_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_mag_compare_ctrl_pkg.sv
// Shared types and constants for the serial magnitude compare controller.
// Holds the FSM state encoding, the sticky result code and the slice width.
package serial_mag_compare_ctrl_pkg;

   localparam int SLICE_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RES_EQ = 2'd0,
      RES_GT = 2'd1,
      RES_LT = 2'd2
   } res_t;

endpackage

// File: rtl/serial_mag_compare_ctrl_greater.sv
// 2-bit unsigned slice comparator: gt_o is high when a_i > b_i.
// The controller uses two copies, one with the operands swapped.
module greater (
   input  logic [1:0] a_i,
   input  logic [1:0] b_i,
   output logic       gt_o
);

   assign gt_o = (a_i > b_i);

endmodule

// File: rtl/serial_mag_compare_ctrl.sv
// Serial magnitude comparator: scans two WIDTH-bit operands one 2-bit slice per cycle,
// most significant slice first, and returns GT/EQ/LT over a valid/ready pair.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both high.
// in_ready is decoded from state only; out_valid and the result flags hold until taken.
module serial_mag_compare_ctrl
   import serial_mag_compare_ctrl_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  bit EARLY_EXIT = 1'b1,
   localparam int SLICES     = WIDTH / 2,
   localparam int CW         = $clog2(SLICES) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_gt,
   output logic             out_eq,
   output logic             out_lt,
   output logic [CW-1:0]    out_slices,
   output logic             busy,
   output logic [1:0]       dbg_state
);

   localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      a_q, a_d, b_q, b_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   res_t                  res_q, res_d;
   logic                  hit_q, hit_d;

   logic [WIDTH-1:0]      a_sh, b_sh;
   logic [SLICE_W-1:0]    s_a, s_b;
   logic                  g, l;

   // Slice select: shift the current slice down to bit 0.
   assign a_sh = a_q >> {idx_q, 1'b0};
   assign b_sh = b_q >> {idx_q, 1'b0};
   assign s_a  = a_sh[SLICE_W-1:0];
   assign s_b  = b_sh[SLICE_W-1:0];

   greater u_gt_ab (.a_i(s_a), .b_i(s_b), .gt_o(g));
   greater u_gt_ba (.a_i(s_b), .b_i(s_a), .gt_o(l));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         res_q   <= RES_EQ;
         hit_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
         hit_q   <= hit_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      hit_d   = hit_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               idx_d   = IW'(SLICES - 1);
               cnt_d   = '0;
               res_d   = RES_EQ;
               hit_d   = 1'b0;
               state_d = CMP;
            end
         end
         CMP: begin
            cnt_d = cnt_q + CW'(1);
            // The first differing slice decides; lower slices never override it.
            if (!hit_q && (g || l)) begin
               hit_d = 1'b1;
               res_d = g ? RES_GT : RES_LT;
            end
            if ((EARLY_EXIT && (g || l)) || (idx_q == '0)) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready   = (state_q == IDLE);
      busy       = (state_q != IDLE);
      out_valid  = (state_q == DONE);
      out_gt     = out_valid && (res_q == RES_GT);
      out_eq     = out_valid && (res_q == RES_EQ);
      out_lt     = out_valid && (res_q == RES_LT);
      out_slices = out_valid ? cnt_q : '0;
      dbg_state  = state_q;
   end

endmodule

// File: tb/tb_serial_mag_compare_ctrl.sv
// Directed bench for serial_mag_compare_ctrl: an 8-bit early-exit instance, an 8-bit
// fixed-latency instance and a 2-bit instance sharing one clock and reset.
module tb_serial_mag_compare_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // early-exit 8-bit instance
   logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic [7:0] in_a = '0, in_b = '0;
   logic       out_gt, out_eq, out_lt, busy;
   logic [2:0] out_slices;
   logic [1:0] dbg_state;

   // fixed-latency 8-bit instance
   logic       fx_in_valid = 1'b0, fx_in_ready, fx_out_valid, fx_out_ready = 1'b0;
   logic [7:0] fx_in_a = '0, fx_in_b = '0;
   logic       fx_out_gt, fx_out_eq, fx_out_lt, fx_busy;
   logic [2:0] fx_out_slices;
   logic [1:0] fx_dbg_state;

   // 2-bit instance
   logic       w2_in_valid = 1'b0, w2_in_ready, w2_out_valid, w2_out_ready = 1'b0;
   logic [1:0] w2_in_a = '0, w2_in_b = '0;
   logic       w2_out_gt, w2_out_eq, w2_out_lt, w2_busy;
   logic [0:0] w2_out_slices;
   logic [1:0] w2_dbg_state;

   serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
      .out_gt(out_gt), .out_eq(out_eq), .out_lt(out_lt), .out_slices(out_slices),
      .busy(busy), .dbg_state(dbg_state)
   );

   serial_mag_compare_ctrl #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut_fx (
      .clk(clk), .rst(rst), .in_valid(fx_in_valid), .in_ready(fx_in_ready),
      .in_a(fx_in_a), .in_b(fx_in_b), .out_valid(fx_out_valid), .out_ready(fx_out_ready),
      .out_gt(fx_out_gt), .out_eq(fx_out_eq), .out_lt(fx_out_lt), .out_slices(fx_out_slices),
      .busy(fx_busy), .dbg_state(fx_dbg_state)
   );

   serial_mag_compare_ctrl #(.WIDTH(2), .EARLY_EXIT(1'b1)) u_dut_w2 (
      .clk(clk), .rst(rst), .in_valid(w2_in_valid), .in_ready(w2_in_ready),
      .in_a(w2_in_a), .in_b(w2_in_b), .out_valid(w2_out_valid), .out_ready(w2_out_ready),
      .out_gt(w2_out_gt), .out_eq(w2_out_eq), .out_lt(w2_out_lt), .out_slices(w2_out_slices),
      .busy(w2_busy), .dbg_state(w2_dbg_state)
   );

   // Driver: present a pair, let it be accepted, count edges (accept edge included)
   // until out_valid rises or a 20-edge budget runs out.
   task automatic send_pair(input logic [7:0] a, input logic [7:0] b, output int lat);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!out_valid && lat < 20);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, out_gt, out_eq, out_lt, busy} !== 6'b100000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=100000",
                  {in_ready, out_valid, out_gt, out_eq, out_lt, busy});
      end
      checks++;
      if (out_slices !== 3'd0) begin
         failures++;
         $display("FAIL reset_slices got=%0d exp=0", out_slices);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL reset_idle in_ready=%b state=%0d exp 1/0", in_ready, dbg_state);
      end
   endtask

   task automatic test_gt_early();
      int lat;
      send_pair(8'hC3, 8'h43, lat);
      checks++;
      if ({out_valid, out_gt, out_eq, out_lt} !== 4'b1100) begin
         failures++;
         $display("FAIL gt_flags got=%b exp=1100", {out_valid, out_gt, out_eq, out_lt});
      end
      checks++;
      if (out_slices !== 3'd1 || lat != 2) begin
         failures++;
         $display("FAIL gt_slices_lat slices=%0d lat=%0d exp 1/2", out_slices, lat);
      end
      release_result();
   endtask

   task automatic test_eq();
      int lat;
      send_pair(8'h5A, 8'h5A, lat);
      checks++;
      if ({out_valid, out_gt, out_eq, out_lt} !== 4'b1010) begin
         failures++;
         $display("FAIL eq_flags got=%b exp=1010", {out_valid, out_gt, out_eq, out_lt});
      end
      checks++;
      if (out_slices !== 3'd4 || lat != 5) begin
         failures++;
         $display("FAIL eq_slices_lat slices=%0d lat=%0d exp 4/5", out_slices, lat);
      end
      release_result();
   endtask

   task automatic test_lt();
      int lat;
      send_pair(8'h12, 8'h13, lat);
      checks++;
      if ({out_valid, out_gt, out_eq, out_lt} !== 4'b1001 || out_slices !== 3'd4 || lat != 5) begin
         failures++;
         $display("FAIL lt_lsb flags=%b slices=%0d lat=%0d exp 1001/4/5",
                  {out_valid, out_gt, out_eq, out_lt}, out_slices, lat);
      end
      release_result();
      send_pair(8'h00, 8'hFF, lat);
      checks++;
      if ({out_valid, out_gt, out_eq, out_lt} !== 4'b1001 || out_slices !== 3'd1 || lat != 2) begin
         failures++;
         $display("FAIL lt_msb flags=%b slices=%0d lat=%0d exp 1001/1/2",
                  {out_valid, out_gt, out_eq, out_lt}, out_slices, lat);
      end
      release_result();
   endtask

   // Result held under back-pressure, new pair offered throughout, including the release edge.
   task automatic test_hold();
      int lat;
      send_pair(8'hC3, 8'h43, lat);
      in_a     = 8'h00;
      in_b     = 8'hFF;
      in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         checks++;
         if ({out_valid, out_gt, out_eq, out_lt, in_ready, busy} !== 6'b110001 ||
             out_slices !== 3'd1) begin
            failures++;
            $display("FAIL hold_cycle%0d flags=%b slices=%0d exp 110001/1", i,
                     {out_valid, out_gt, out_eq, out_lt, in_ready, busy}, out_slices);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      checks++;
      if ({out_valid, out_gt, in_ready, busy} !== 4'b0010) begin
         failures++;
         $display("FAIL hold_release got=%b exp=0010", {out_valid, out_gt, in_ready, busy});
      end
      // pair still offered: accepted on this edge, not the release edge
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 1;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!out_valid && lat < 20);
      checks++;
      if ({out_valid, out_lt} !== 2'b11 || out_slices !== 3'd1 || lat != 2) begin
         failures++;
         $display("FAIL hold_next valid_lt=%b slices=%0d lat=%0d exp 11/1/2",
                  {out_valid, out_lt}, out_slices, lat);
      end
      release_result();
   endtask

   task automatic test_rst_midflight();
      int lat;
      bit seen = 1'b0;
      in_a     = 8'h01;
      in_b     = 8'h02;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      in_a = 8'hFF;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if ({in_ready, out_valid, busy} !== 3'b100 || dbg_state !== 2'd0) begin
         failures++;
         $display("FAIL rst_mid_idle got=%b state=%0d exp 100/0", {in_ready, out_valid, busy}, dbg_state);
      end
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1 if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL rst_mid_no_valid got=1 exp=0");
      end
      send_pair(8'h80, 8'h7F, lat);
      checks++;
      if ({out_valid, out_gt, out_eq, out_lt} !== 4'b1100 || out_slices !== 3'd1 || lat != 2) begin
         failures++;
         $display("FAIL rst_mid_next flags=%b slices=%0d lat=%0d exp 1100/1/2",
                  {out_valid, out_gt, out_eq, out_lt}, out_slices, lat);
      end
      release_result();
   endtask

   task automatic test_fixed_latency();
      int lat;
      fx_in_a     = 8'hC3;
      fx_in_b     = 8'h43;
      fx_in_valid = 1'b1;
      @(posedge clk);
      #1 fx_in_valid = 1'b0;
      lat = 1;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!fx_out_valid && lat < 20);
      checks++;
      if ({fx_out_valid, fx_out_gt, fx_out_eq, fx_out_lt} !== 4'b1100) begin
         failures++;
         $display("FAIL fixed_gt_flags got=%b exp=1100",
                  {fx_out_valid, fx_out_gt, fx_out_eq, fx_out_lt});
      end
      checks++;
      if (fx_out_slices !== 3'd4 || lat != 5) begin
         failures++;
         $display("FAIL fixed_gt_slices_lat slices=%0d lat=%0d exp 4/5", fx_out_slices, lat);
      end
      fx_out_ready = 1'b1;
      @(posedge clk);
      #1 fx_out_ready = 1'b0;
      checks++;
      if (fx_out_valid !== 1'b0 || fx_in_ready !== 1'b1) begin
         failures++;
         $display("FAIL fixed_release valid=%b ready=%b exp 0/1", fx_out_valid, fx_in_ready);
      end
   endtask

   task automatic test_w2();
      int lat;
      w2_in_a     = 2'b10;
      w2_in_b     = 2'b01;
      w2_in_valid = 1'b1;
      @(posedge clk);
      #1 w2_in_valid = 1'b0;
      lat = 1;
      do begin
         @(posedge clk);
         #1 lat++;
      end while (!w2_out_valid && lat < 20);
      checks++;
      if ({w2_out_valid, w2_out_gt, w2_out_eq, w2_out_lt} !== 4'b1100 ||
          w2_out_slices !== 1'b1 || lat != 2) begin
         failures++;
         $display("FAIL w2_gt flags=%b slices=%0d lat=%0d exp 1100/1/2",
                  {w2_out_valid, w2_out_gt, w2_out_eq, w2_out_lt}, w2_out_slices, lat);
      end
      w2_out_ready = 1'b1;
      @(posedge clk);
      #1 w2_out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_gt_early();
      test_eq();
      test_lt();
      test_hold();
      test_rst_midflight();
      test_fixed_latency();
      test_w2();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
